// File: rtl/key_scan.sv
// 4x4 keypad scanner: walks an active-low column strobe, samples synchronized rows,
// and publishes a 16-key active-low snapshot plus a new-press event once per frame.
module key_scan #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scan_en,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] key_out,
  output logic        frame_done,
  output logic        key_evt,
  output logic [3:0]  key_code
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]       row_p0;
  logic [3:0]       row_p1;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col;
  logic [11:0]      frame_buf;

  logic             slot_end;
  logic [15:0]      frame_new;
  logic [15:0]      new_press;

  function automatic logic [3:0] lowest_idx(input logic [15:0] mask);
    lowest_idx = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) lowest_idx = 4'(i);
    end
  endfunction

  assign slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_new = {row_p1, frame_buf};
  assign new_press = key_out & ~frame_new;

  // Stage p0/p1: two-flop synchronizer for the asynchronous row pins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_p0 <= 4'b1111;
      row_p1 <= 4'b1111;
    end else begin
      row_p0 <= row_in;
      row_p1 <= row_p0;
    end
  end

  // Scan sequencer, column buffer and frame commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      col        <= 2'd0;
      col_out    <= 4'b1111;
      frame_buf  <= 12'hfff;
      key_out    <= 16'hffff;
      frame_done <= 1'b0;
      key_evt    <= 1'b0;
      key_code   <= 4'h0;
    end else begin
      frame_done <= 1'b0;
      key_evt    <= 1'b0;
      if (!scan_en) begin
        cnt       <= '0;
        col       <= 2'd0;
        col_out   <= 4'b1111;
        frame_buf <= 12'hfff;
      end else begin
        col_out <= ~(4'b0001 << col);
        if (slot_end) begin
          cnt <= '0;
          col <= col + 2'd1;
          case (col)
            2'd0:    frame_buf[3:0]  <= row_p1;
            2'd1:    frame_buf[7:4]  <= row_p1;
            2'd2:    frame_buf[11:8] <= row_p1;
            default: begin
              // Last column: its rows go straight into the snapshot
              key_out    <= frame_new;
              frame_done <= 1'b1;
              if (new_press != 16'h0000) begin
                key_evt  <= 1'b1;
                key_code <= lowest_idx(new_press);
              end
            end
          endcase
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
